// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters, sync/DE decode and pixel-slot delay line
// Decode is computed from the next counter values so de/syncs never lag x/y.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int SYNC_NEG  = 1,
    parameter int ALIGN_DLY = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pix_en,
    output logic [11:0] o_x,
    output logic [11:0] o_y,
    output logic        o_de,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_frame_start,
    output logic        o_de_d,
    output logic        o_hsync_d,
    output logic        o_vsync_d
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_MAX  = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_MAX  = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_VIS  = 12'(H_ACTIVE);
    localparam logic [11:0] V_VIS  = 12'(V_ACTIVE);
    localparam logic [11:0] HS_ON  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_OFF = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_ON  = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_OFF = 12'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic       SYNC_IDLE = (SYNC_NEG != 0);
    localparam logic [2:0] DLY_IDLE  = {1'b0, SYNC_IDLE, SYNC_IDLE};

    logic [11:0] x, y, x_nxt, y_nxt;
    logic        de, hsync, vsync, frame_start;
    logic        de_nxt, hs_nxt, vs_nxt;
    logic [2:0]  dly_out;

    always_comb begin
        x_nxt = x;
        y_nxt = y;
        if (x == H_MAX) begin
            x_nxt = '0;
            y_nxt = (y == V_MAX) ? '0 : y + 12'd1;
        end else begin
            x_nxt = x + 12'd1;
        end
        de_nxt = (x_nxt < H_VIS) && (y_nxt < V_VIS);
        hs_nxt = ((x_nxt >= HS_ON) && (x_nxt < HS_OFF)) ? ~SYNC_IDLE : SYNC_IDLE;
        vs_nxt = ((y_nxt >= VS_ON) && (y_nxt < VS_OFF)) ? ~SYNC_IDLE : SYNC_IDLE;
    end

    // Reset parks the counters on the last slot so the first strobe wraps into (0,0)
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            x           <= H_MAX;
            y           <= V_MAX;
            de          <= 1'b0;
            hsync       <= SYNC_IDLE;
            vsync       <= SYNC_IDLE;
            frame_start <= 1'b0;
        end else begin
            frame_start <= i_pix_en && (x_nxt == '0) && (y_nxt == '0);
            if (i_pix_en) begin
                x     <= x_nxt;
                y     <= y_nxt;
                de    <= de_nxt;
                hsync <= hs_nxt;
                vsync <= vs_nxt;
            end
        end
    end

    generate
        if (ALIGN_DLY == 0) begin : g_nodly
            assign dly_out = {de, hsync, vsync};
        end else begin : g_dly
            logic [2:0] stage [ALIGN_DLY];
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int i = 0; i < ALIGN_DLY; i++) stage[i] <= DLY_IDLE;
                end else if (i_pix_en) begin
                    stage[0] <= {de, hsync, vsync};
                    for (int i = 1; i < ALIGN_DLY; i++) stage[i] <= stage[i-1];
                end
            end
            assign dly_out = stage[ALIGN_DLY-1];
        end
    endgenerate

    assign o_x           = x;
    assign o_y           = y;
    assign o_de          = de;
    assign o_hsync       = hsync;
    assign o_vsync       = vsync;
    assign o_frame_start = frame_start;
    assign o_de_d        = dly_out[2];
    assign o_hsync_d     = dly_out[1];
    assign o_vsync_d     = dly_out[0];
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - bench for vga_timing_gen: default and small-raster instances
module tb_vga_timing_gen;
    localparam int S_HA = 10, S_HFP = 2, S_HS = 3, S_HBP = 5;
    localparam int S_VA = 6,  S_VFP = 2, S_VS = 2, S_VBP = 3;
    localparam int S_DLY = 3;

    typedef struct { int ha, hfp, hsw, hbp, va, vfp, vsw, vbp; bit neg; int dly; } prm_t;
    typedef struct { int x, y; bit de, hs, vs, fs; bit [3:0][2:0] dl; } mst_t;
    typedef struct packed { logic [30:0] d; logic [30:0] s; } exp_t;
    typedef struct { bit rst; bit en; int n; logic [30:0] exp; } vec_t;

    logic clk, rst, pix_en;
    logic [11:0] def_x, def_y, sml_x, sml_y;
    logic def_de, def_hs, def_vs, def_fs, def_de_d, def_hs_d, def_vs_d;
    logic sml_de, sml_hs, sml_vs, sml_fs, sml_de_d, sml_hs_d, sml_vs_d;
    logic [30:0] obs_def, obs_sml;

    int total, bad;
    prm_t p_def, p_sml;
    mst_t m_def, m_sml;
    exp_t sb[$];
    vec_t vt[16];
    int hs_cnt, strobes, vs_cnt, de_cnt, frames, fs_double, late_de, guard;
    bit seen, prev_fs, e;

    vga_timing_gen u_def (
        .i_clk(clk), .i_rst(rst), .i_pix_en(pix_en),
        .o_x(def_x), .o_y(def_y), .o_de(def_de), .o_hsync(def_hs), .o_vsync(def_vs),
        .o_frame_start(def_fs), .o_de_d(def_de_d), .o_hsync_d(def_hs_d), .o_vsync_d(def_vs_d)
    );

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .SYNC_NEG(0), .ALIGN_DLY(S_DLY)
    ) u_sml (
        .i_clk(clk), .i_rst(rst), .i_pix_en(pix_en),
        .o_x(sml_x), .o_y(sml_y), .o_de(sml_de), .o_hsync(sml_hs), .o_vsync(sml_vs),
        .o_frame_start(sml_fs), .o_de_d(sml_de_d), .o_hsync_d(sml_hs_d), .o_vsync_d(sml_vs_d)
    );

    assign obs_def = {def_x, def_y, def_de, def_hs, def_vs, def_fs, def_de_d, def_hs_d, def_vs_d};
    assign obs_sml = {sml_x, sml_y, sml_de, sml_hs, sml_vs, sml_fs, sml_de_d, sml_hs_d, sml_vs_d};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

    function automatic logic [30:0] pk(int x, int y, bit de, bit hs, bit vs, bit fs,
                                       bit dd, bit hd, bit vd);
        return {12'(x), 12'(y), de, hs, vs, fs, dd, hd, vd};
    endfunction

    function automatic mst_t m_reset(prm_t p);
        mst_t n;
        n.x  = p.ha + p.hfp + p.hsw + p.hbp - 1;
        n.y  = p.va + p.vfp + p.vsw + p.vbp - 1;
        n.de = 1'b0;
        n.hs = p.neg;
        n.vs = p.neg;
        n.fs = 1'b0;
        for (int i = 0; i < 4; i++) n.dl[i] = {1'b0, p.neg, p.neg};
        return n;
    endfunction

    function automatic mst_t m_step(mst_t s, prm_t p, bit r, bit en);
        mst_t n;
        int htot, vtot;
        bit act;
        if (r) return m_reset(p);
        n = s;
        n.fs = 1'b0;
        if (en) begin
            for (int i = 3; i > 0; i--) n.dl[i] = s.dl[i-1];
            n.dl[0] = {s.de, s.hs, s.vs};
            htot = p.ha + p.hfp + p.hsw + p.hbp;
            vtot = p.va + p.vfp + p.vsw + p.vbp;
            if (s.x == htot - 1) begin
                n.x = 0;
                n.y = (s.y == vtot - 1) ? 0 : s.y + 1;
            end else begin
                n.x = s.x + 1;
            end
            act  = !p.neg;
            n.de = (n.x < p.ha) && (n.y < p.va);
            n.hs = (n.x >= p.ha + p.hfp && n.x < p.ha + p.hfp + p.hsw) ? act : !act;
            n.vs = (n.y >= p.va + p.vfp && n.y < p.va + p.vfp + p.vsw) ? act : !act;
            n.fs = (n.x == 0) && (n.y == 0);
        end
        return n;
    endfunction

    function automatic logic [30:0] m_obs(mst_t s, prm_t p);
        bit [2:0] d;
        d = (p.dly == 0) ? {s.de, s.hs, s.vs} : s.dl[p.dly-1];
        return pk(s.x, s.y, s.de, s.hs, s.vs, s.fs, d[2], d[1], d[0]);
    endfunction

    task automatic check(input string nm, input logic [30:0] act, input logic [30:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // One clock: drive, predict into the scoreboard, then compare once the DUT has settled
    task automatic tick(input bit r, input bit en);
        exp_t ex;
        rst    = r;
        pix_en = en;
        m_def  = m_step(m_def, p_def, r, en);
        m_sml  = m_step(m_sml, p_sml, r, en);
        ex.d   = m_obs(m_def, p_def);
        ex.s   = m_obs(m_sml, p_sml);
        sb.push_back(ex);
        @(posedge clk);
        #1;
        ex = sb.pop_front();
        check("sb_def", obs_def, ex.d);
        check("sb_sml", obs_sml, ex.s);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst    = 1'b1;
        pix_en = 1'b0;
        p_def = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 1};
        p_sml = '{S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, 1'b0, S_DLY};
        m_def = m_reset(p_def);
        m_sml = m_reset(p_sml);

        vt[0]  = '{1'b1, 1'b1, 3,   pk(799, 524, 0, 1, 1, 0, 0, 1, 1)};
        vt[1]  = '{1'b0, 1'b1, 1,   pk(0,   0,   1, 1, 1, 1, 0, 1, 1)};
        vt[2]  = '{1'b0, 1'b1, 1,   pk(1,   0,   1, 1, 1, 0, 1, 1, 1)};
        vt[3]  = '{1'b0, 1'b1, 638, pk(639, 0,   1, 1, 1, 0, 1, 1, 1)};
        vt[4]  = '{1'b0, 1'b1, 1,   pk(640, 0,   0, 1, 1, 0, 1, 1, 1)};
        vt[5]  = '{1'b0, 1'b1, 1,   pk(641, 0,   0, 1, 1, 0, 0, 1, 1)};
        vt[6]  = '{1'b0, 1'b1, 14,  pk(655, 0,   0, 1, 1, 0, 0, 1, 1)};
        vt[7]  = '{1'b0, 1'b1, 1,   pk(656, 0,   0, 0, 1, 0, 0, 1, 1)};
        vt[8]  = '{1'b0, 1'b1, 1,   pk(657, 0,   0, 0, 1, 0, 0, 0, 1)};
        vt[9]  = '{1'b0, 1'b0, 3,   pk(657, 0,   0, 0, 1, 0, 0, 0, 1)};
        vt[10] = '{1'b0, 1'b1, 95,  pk(752, 0,   0, 1, 1, 0, 0, 0, 1)};
        vt[11] = '{1'b0, 1'b1, 47,  pk(799, 0,   0, 1, 1, 0, 0, 1, 1)};
        vt[12] = '{1'b0, 1'b1, 1,   pk(0,   1,   1, 1, 1, 0, 0, 1, 1)};
        vt[13] = '{1'b0, 1'b1, 300, pk(300, 1,   1, 1, 1, 0, 1, 1, 1)};
        vt[14] = '{1'b1, 1'b1, 3,   pk(799, 524, 0, 1, 1, 0, 0, 1, 1)};
        vt[15] = '{1'b0, 1'b1, 1,   pk(0,   0,   1, 1, 1, 1, 0, 1, 1)};

        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < vt[i].n; k++) tick(vt[i].rst, vt[i].en);
            check($sformatf("vec%0d", i), obs_def, vt[i].exp);
        end

        // frame_start must drop after one clock even with the strobe low at (0,0)
        tick(1'b0, 1'b0);
        check_int("fs_one_clock", int'(def_fs), 0);

        guard = 0;
        while (def_x != 12'd650 && guard < 1000) begin
            tick(1'b0, 1'b1);
            guard++;
        end
        check_int("reach_x650", int'(def_x), 650);

        hs_cnt = 0;
        for (int k = 0; k < 300; k++) begin
            e = (k % 2 == 0);
            tick(1'b0, e);
            if (e && def_hs == 1'b0) hs_cnt++;
        end
        check_int("hs_width_toggled", hs_cnt, 96);

        strobes = 0; vs_cnt = 0; de_cnt = 0; frames = 0;
        fs_double = 0; late_de = 0; seen = 1'b0; prev_fs = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            e = ($urandom_range(0, 2) != 0);
            tick(1'b0, e);
            if (sml_fs && prev_fs) fs_double++;
            if (e) begin
                strobes++;
                if (sml_vs) vs_cnt++;
                if (sml_de) de_cnt++;
                if (sml_de && sml_y >= 12'(S_VA)) late_de++;
            end
            if (sml_fs) begin
                if (seen) begin
                    check_int("frame_strobes", strobes, 260);
                    check_int("vsync_slots", vs_cnt, 40);
                    check_int("de_slots", de_cnt, 60);
                    frames++;
                end
                seen = 1'b1;
                strobes = 0; vs_cnt = 0; de_cnt = 0;
            end
            prev_fs = sml_fs;
        end
        check_int("frames_seen", int'(frames >= 2), 1);
        check_int("fs_single_clock", fs_double, 0);
        check_int("no_de_blank_rows", late_de, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
